// File: rtl/video_timing_overlay.sv
// rtl/video_timing_overlay.sv - raster timing generator with frame-buffer fetch and text-window overlays
// Optional keyed overlays (TXT_PX == 0 shows the underlying pixel): define VTO_TRANSPARENT_EN.
module video_timing_overlay #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int N_OVL    = 2,
  parameter int OVL_W    = 100,
  parameter int OVL_H    = 10,
  parameter int ADDR_W   = $clog2(H_ACTIVE*V_ACTIVE),
  parameter int TADDR_W  = $clog2(N_OVL*OVL_W*OVL_H)
)(
  input  logic                 CLK_PX,
  input  logic                 RST_n,
  input  logic                 EN,
  input  logic [1:0]           MODE,
  input  logic [N_OVL-1:0]     OVL_EN,
  input  logic [12*N_OVL-1:0]  OVL_X,
  input  logic [12*N_OVL-1:0]  OVL_Y,
  input  logic [23:0]          PX,
  input  logic [7:0]           TXT_PX,
  output logic [ADDR_W-1:0]    PX_ADDR,
  output logic [TADDR_W-1:0]   TXT_ADDR,
  output logic                 HDMI_CLK,
  output logic                 DE,
  output logic                 HSYNC,
  output logic                 VSYNC,
  output logic [23:0]          HDMI_PX,
  output logic                 FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  logic [HC_W-1:0]    hc, hc_n, x1;
  logic [VC_W-1:0]    vc, vc_n;
  logic               act0, hs0, vs0, hit0;
  logic               origin_n, act_n, use_live, hit_n;
  logic               act1, hs1, vs1, hit1;
  logic [N_OVL-1:0]   ovl_en_q, cfg_en;
  logic [12*N_OVL-1:0] ovl_x_q, ovl_y_q, cfg_x, cfg_y;
  logic [13:0]        x14, y14, ox, oy;
  logic [TADDR_W-1:0] taddr_n;
  logic [2:0]         bar_k;
  logic [23:0]        base_px, px_n;
  logic               show_txt;
  int                 offs;

  assign HDMI_CLK    = CLK_PX;
  assign FRAME_START = RST_n && EN && (hc == '0) && (vc == '0);

  assign act0 = EN && (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
  assign hs0  = EN && (int'(hc) >= H_ACTIVE + H_FP) && (int'(hc) < H_ACTIVE + H_FP + H_SYNC);
  assign vs0  = EN && (int'(vc) >= V_ACTIVE + V_FP) && (int'(vc) < V_ACTIVE + V_FP + V_SYNC);

  always_comb begin
    hc_n = '0;
    vc_n = '0;
    if (EN) begin
      if (hc == HC_W'(H_TOTAL-1)) begin
        hc_n = '0;
        vc_n = (vc == VC_W'(V_TOTAL-1)) ? '0 : vc + VC_W'(1);
      end else begin
        hc_n = hc + HC_W'(1);
        vc_n = vc;
      end
    end
  end

  assign origin_n = (hc_n == '0) && (vc_n == '0);
  assign act_n    = (int'(hc_n) < H_ACTIVE) && (int'(vc_n) < V_ACTIVE);

  // Addresses are registered from the next position so they line up with the
  // stage-0 counters; the window set in force is the one latched at frame start.
  assign use_live = origin_n || FRAME_START;
  assign cfg_en   = use_live ? OVL_EN : ovl_en_q;
  assign cfg_x    = use_live ? OVL_X  : ovl_x_q;
  assign cfg_y    = use_live ? OVL_Y  : ovl_y_q;

  always_comb begin
    hit_n   = 1'b0;
    taddr_n = TXT_ADDR;
    offs    = 0;
    ox      = '0;
    oy      = '0;
    x14     = 14'(hc_n);
    y14     = 14'(vc_n);
    // Descending scan so the lowest-index window is the last to assign.
    for (int i = N_OVL-1; i >= 0; i--) begin
      ox = 14'(cfg_x[12*i +: 12]);
      oy = 14'(cfg_y[12*i +: 12]);
      if (act_n && cfg_en[i] &&
          (x14 >= ox) && (x14 < ox + 14'(OVL_W)) &&
          (y14 >= oy) && (y14 < oy + 14'(OVL_H))) begin
        hit_n   = 1'b1;
        offs    = i*OVL_W*OVL_H + int'(y14 - oy)*OVL_W + int'(x14 - ox);
        taddr_n = offs[TADDR_W-1:0];
      end
    end
    if (!EN) taddr_n = '0;
  end

  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      hc       <= '0;
      vc       <= '0;
      PX_ADDR  <= '0;
      TXT_ADDR <= '0;
      hit0     <= 1'b0;
      ovl_en_q <= '0;
      ovl_x_q  <= '0;
      ovl_y_q  <= '0;
    end else begin
      hc       <= hc_n;
      vc       <= vc_n;
      TXT_ADDR <= taddr_n;
      hit0     <= hit_n && EN;
      // Active pixels are contiguous in raster order, so a held address plus one
      // is always the next active pixel.
      if (!EN || origin_n)
        PX_ADDR <= '0;
      else if (act_n)
        PX_ADDR <= PX_ADDR + ADDR_W'(1);
      if (FRAME_START) begin
        ovl_en_q <= OVL_EN;
        ovl_x_q  <= OVL_X;
        ovl_y_q  <= OVL_Y;
      end
    end
  end

  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      act1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      hit1 <= 1'b0;
      x1   <= '0;
    end else begin
      act1 <= act0;
      hs1  <= hs0;
      vs1  <= vs0;
      hit1 <= hit0 && EN;
      x1   <= hc;
    end
  end

  always_comb begin
    bar_k = 3'((int'(x1) * 8) / H_ACTIVE);
    case (MODE)
      2'd0:    base_px = {3{PX[7:0]}};
      2'd1:    base_px = PX;
      2'd2:    base_px = ~{3{PX[7:0]}};
      default: base_px = {{8{bar_k[2]}}, {8{bar_k[1]}}, {8{bar_k[0]}}};
    endcase
`ifdef VTO_TRANSPARENT_EN
    show_txt = hit1 && (TXT_PX != 8'h00);
`else
    show_txt = hit1;
`endif
    px_n = show_txt ? {3{TXT_PX}} : base_px;
  end

  // Output stage drops to idle one edge after EN falls rather than draining.
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      DE      <= 1'b0;
      HSYNC   <= ~HS_POL;
      VSYNC   <= ~VS_POL;
      HDMI_PX <= '0;
    end else if (!EN) begin
      DE      <= 1'b0;
      HSYNC   <= ~HS_POL;
      VSYNC   <= ~VS_POL;
      HDMI_PX <= '0;
    end else begin
      DE      <= act1;
      HSYNC   <= hs1 ? HS_POL : ~HS_POL;
      VSYNC   <= vs1 ? VS_POL : ~VS_POL;
      HDMI_PX <= act1 ? px_n : 24'h0;
    end
  end

endmodule

// File: tb/tb_video_timing_overlay.sv
// tb/tb_video_timing_overlay.sv - scoreboard bench for video_timing_overlay on a 16x8 raster
module tb_video_timing_overlay;

  localparam int H_ACT = 8, H_FP = 2, H_SY = 3, H_BP = 3;
  localparam int V_ACT = 4, V_FP = 1, V_SY = 2, V_BP = 1;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int NW = 2, OW = 2, OH = 2;
  localparam int AW = $clog2(H_ACT*V_ACT);
  localparam int TW = $clog2(NW*OW*OH);

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] px;
  } exp_t;

  logic           CLK_PX = 1'b0;
  logic           RST_n, EN;
  logic [1:0]     MODE;
  logic [NW-1:0]  OVL_EN;
  logic [12*NW-1:0] OVL_X, OVL_Y;
  logic [23:0]    px_q;
  logic [7:0]     txt_q;
  logic [AW-1:0]  PX_ADDR;
  logic [TW-1:0]  TXT_ADDR;
  logic           HDMI_CLK, DE, HSYNC, VSYNC, FRAME_START;
  logic [23:0]    HDMI_PX;

  logic           txt_zero;
  int             n_checks = 0;
  int             n_fail = 0;
  int             m_hc, m_vc, m_hold;
  logic [NW-1:0]  m_en;
  logic [12*NW-1:0] m_ox, m_oy;
  exp_t           sb[$];

  video_timing_overlay #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .N_OVL(NW), .OVL_W(OW), .OVL_H(OH)
  ) dut (
    .CLK_PX(CLK_PX), .RST_n(RST_n), .EN(EN), .MODE(MODE),
    .OVL_EN(OVL_EN), .OVL_X(OVL_X), .OVL_Y(OVL_Y),
    .PX(px_q), .TXT_PX(txt_q),
    .PX_ADDR(PX_ADDR), .TXT_ADDR(TXT_ADDR),
    .HDMI_CLK(HDMI_CLK), .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .HDMI_PX(HDMI_PX), .FRAME_START(FRAME_START)
  );

  always #5 CLK_PX = ~CLK_PX;

  // Frame buffer echoes its address; text ROM returns A0|addr (or 0 when keyed).
  always @(posedge CLK_PX) begin
    px_q  <= 24'(PX_ADDR);
    txt_q <= txt_zero ? 8'h00 : (8'hA0 | 8'(TXT_ADDR));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_de"},       32'(DE),          32'd0);
    check_eq({tag, "_hdmi_px"},  32'(HDMI_PX),     32'd0);
    check_eq({tag, "_hsync"},    32'(HSYNC),       32'd1);
    check_eq({tag, "_vsync"},    32'(VSYNC),       32'd1);
    check_eq({tag, "_fs"},       32'(FRAME_START), 32'd0);
    check_eq({tag, "_px_addr"},  32'(PX_ADDR),     32'd0);
    check_eq({tag, "_txt_addr"}, 32'(TXT_ADDR),    32'd0);
  endtask

  task automatic reset_model();
    exp_t idle;
    idle.de = 1'b0; idle.hs = 1'b1; idle.vs = 1'b1; idle.px = 24'h0;
    m_hc = 0; m_vc = 0; m_hold = 0;
    sb.delete();
    sb.push_back(idle);
    sb.push_back(idle);
  endtask

  task automatic set_win(input int i, input int x, input int y);
    OVL_X[12*i +: 12] = 12'(x);
    OVL_Y[12*i +: 12] = 12'(y);
  endtask

  task automatic cycle();
    int          x, y, hit_i, ta, a, ox, oy;
    bit          act;
    logic [7:0]  txt;
    logic [23:0] pv, base;
    logic [2:0]  k;
    exp_t        e, g;
    #1;
    x = m_hc;
    y = m_vc;
    if (x == 0 && y == 0) begin
      m_en = OVL_EN; m_ox = OVL_X; m_oy = OVL_Y;
    end
    act = (x < H_ACT) && (y < V_ACT);
    a   = y*H_ACT + x;
    check_eq("frame_start", 32'(FRAME_START), 32'(x == 0 && y == 0));
    check_eq("px_addr", 32'(PX_ADDR), act ? a : m_hold);
    if (act) m_hold = a;

    hit_i = -1;
    ta = 0;
    for (int i = NW-1; i >= 0; i--) begin
      ox = int'(m_ox[12*i +: 12]);
      oy = int'(m_oy[12*i +: 12]);
      if (act && m_en[i] && x >= ox && x < ox + OW && y >= oy && y < oy + OH) begin
        hit_i = i;
        ta = i*OW*OH + (y - oy)*OW + (x - ox);
      end
    end
    if (hit_i >= 0) check_eq("txt_addr", 32'(TXT_ADDR), ta);

    pv = 24'(a);
    k  = 3'(x*8/H_ACT);
    case (MODE)
      2'd0:    base = {3{pv[7:0]}};
      2'd1:    base = pv;
      2'd2:    base = ~{3{pv[7:0]}};
      default: base = {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endcase
    txt = txt_zero ? 8'h00 : (8'hA0 | 8'(ta));
    e.de = act;
    e.hs = !(x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SY);
    e.vs = !(y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SY);
`ifdef VTO_TRANSPARENT_EN
    e.px = !act ? 24'h0 : (hit_i >= 0 && txt != 8'h00) ? {3{txt}} : base;
`else
    e.px = !act ? 24'h0 : (hit_i >= 0) ? {3{txt}} : base;
`endif
    sb.push_back(e);
    if (sb.size() > 2) begin
      g = sb.pop_front();
      check_eq("de",      32'(DE),      32'(g.de));
      check_eq("hsync",   32'(HSYNC),   32'(g.hs));
      check_eq("vsync",   32'(VSYNC),   32'(g.vs));
      check_eq("hdmi_px", 32'(HDMI_PX), 32'(g.px));
    end

    m_hc++;
    if (m_hc == H_TOT) begin
      m_hc = 0;
      m_vc = (m_vc + 1) % V_TOT;
    end
    @(negedge CLK_PX);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    RST_n = 1'b0; EN = 1'b1; MODE = 2'd1; OVL_EN = '0;
    OVL_X = '0; OVL_Y = '0; txt_zero = 1'b0;
    m_en = '0; m_ox = '0; m_oy = '0;
    repeat (3) @(negedge CLK_PX);
    check_idle("reset");

    RST_n = 1'b1;
    reset_model();
    run(2*H_TOT*V_TOT);
    MODE = 2'd0; run(H_TOT*V_TOT);
    MODE = 2'd2; run(H_TOT*V_TOT);
    MODE = 2'd3; run(H_TOT*V_TOT);

    MODE = 2'd1; OVL_EN = 2'b11;
    set_win(0, 1, 1);
    set_win(1, 2, 1);
    run(H_TOT*V_TOT);
    run(40);
    set_win(0, 4, 1);
    set_win(1, 7, 3);
    run(H_TOT*V_TOT - 40);
    run(H_TOT*V_TOT);
    txt_zero = 1'b1; run(H_TOT*V_TOT);
    txt_zero = 1'b0; run(20);

    EN = 1'b0;
    sb.delete();
    #1 check_eq("fs_en_low", 32'(FRAME_START), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK_PX);
      check_idle("en_low");
    end
    EN = 1'b1;
    reset_model();
    run(130);
    run(48);

    RST_n = 1'b0;
    sb.delete();
    #1 check_idle("rst_mid");
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK_PX);
      check_idle("rst_hold");
    end
    RST_n = 1'b1;
    reset_model();
    run(140);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_overlay.md
VIDEO_TIMING_OVERLAY -- requirements
Module: video_timing_overlay

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameters HS_POL / VS_POL, default 0 / 0, asserted sync level.
REQ-006 Parameters N_OVL / OVL_W / OVL_H, defaults 2 / 100 / 10, overlay window count (1-4) and window size in pixels.
REQ-007 Derived widths: ADDR_W = clog2(H_ACTIVE*V_ACTIVE) and TADDR_W = clog2(N_OVL*OVL_W*OVL_H).
REQ-008 Port CLK_PX, in, 1, pixel clock.
REQ-009 Port RST_n, in, 1, reset: asynchronous, active-low.
REQ-010 Port EN, in, 1, timing enable.
REQ-011 Port MODE, in, 2: 0 = gray, 1 = RGB, 2 = inverted gray, 3 = colour bars.
REQ-012 Port OVL_EN, in, N_OVL, per-window enable.
REQ-013 Ports OVL_X / OVL_Y, in, 12*N_OVL each, window top-left corners in active coordinates.
REQ-014 Port PX, in, 24, frame-buffer data, 1-cycle read latency.
REQ-015 Port TXT_PX, in, 8, text-ROM data, 1-cycle read latency.
REQ-016 Port PX_ADDR, out, ADDR_W, frame-buffer address.
REQ-017 Port TXT_ADDR, out, TADDR_W, text-ROM address.
REQ-018 Ports HDMI_CLK (1) = CLK_PX; DE (1); HSYNC (1); VSYNC (1); HDMI_PX (24); FRAME_START (1); all outputs.

Function
REQ-019 The block SHALL run counter hc over 0..H_TOTAL-1 (H_TOTAL = sum of the horizontal parameters) in the order active, FP, sync, BP; vc SHALL advance on hc wrap over 0..V_TOTAL-1.
REQ-020 The stage-0 signal act SHALL equal (hc<H_ACTIVE)&&(vc<V_ACTIVE).
REQ-021 The stage-0 sync signals SHALL be asserted within their sync intervals.
REQ-022 PX_ADDR SHALL be vc*H_ACTIVE+hc while act, SHALL hold its value outside act, and SHALL be 0 at hc=0,vc=0.
REQ-023 Window i SHALL be hit when OVL_EN[i] is set, x lies in [OVL_X_i, OVL_X_i+OVL_W) and y lies in [OVL_Y_i, OVL_Y_i+OVL_H).
REQ-024 When several windows are hit, the lowest-index window SHALL win.
REQ-025 Window arithmetic SHALL be at least 13 bits wide so that a window at the screen edge never wraps.
REQ-026 TXT_ADDR SHALL be i*OVL_W*OVL_H + (y-OVL_Y_i)*OVL_W + (x-OVL_X_i) for the winning window i.
REQ-027 OVL_EN, OVL_X and OVL_Y SHALL be sampled only when FRAME_START is asserted, so mid-frame changes take effect from the next frame.
REQ-028 Pipeline: stage 1 SHALL drive the addresses; stage 2 SHALL register DE, the syncs and HDMI_PX. Outputs SHALL lag their counter position by exactly 2 cycles.
REQ-029 In an overlay hit, HDMI_PX SHALL be {TXT_PX,TXT_PX,TXT_PX}, independent of MODE.
REQ-030 With no overlay hit, HDMI_PX SHALL be: MODE 0 -> {PX[7:0] x3}; MODE 1 -> PX; MODE 2 -> ~{PX[7:0] x3}; MODE 3 -> 8 equal vertical bars, bar k = {k[2]?FF:00, k[1]?FF:00, k[0]?FF:00}, k = x*8/H_ACTIVE.
REQ-031 HDMI_PX SHALL be 0 whenever DE is 0.
REQ-032 A MODE change SHALL take effect on the next pixel with no glitch on DE or the syncs.
REQ-033 FRAME_START SHALL pulse for one cycle when the counters are at hc=0,vc=0 (stage 0).
REQ-034 While EN is 0, hc, vc, PX_ADDR and TXT_ADDR SHALL be held at 0, DE and HDMI_PX SHALL be 0, the syncs SHALL be deasserted, and FRAME_START SHALL be 0.
REQ-035 On EN rising, the first FRAME_START SHALL occur in the same cycle.

Reset
REQ-036 While RST_n is 0: hc=vc=0, PX_ADDR=0, TXT_ADDR=0, DE=0, HDMI_PX=0, HSYNC=!HS_POL, VSYNC=!VS_POL, FRAME_START=0, pipeline cleared, latched overlay enables=0.
REQ-037 Reset asserted mid-frame SHALL force these values immediately; after release the first active cycle SHALL be a frame start.

Configuration
REQ-038 Macro VTO_TRANSPARENT_EN: when defined, TXT_PX==8'h00 inside a window SHALL show the non-overlay pixel; when undefined, overlays SHALL be opaque.

Verification (small params: H 8/2/3/3, V 4/1/2/1, N_OVL=2, OVL_W=2, OVL_H=2)
REQ-039 Release reset with EN=1 -> FRAME_START at cycle 0, DE high for output cycles 2..9 of each line, HSYNC low for 3 cycles, frame period 128 cycles.
REQ-040 MODE=1 with PX driven as PX_ADDR echo -> HDMI_PX sequence 0..31 over the 32 DE cycles; PX_ADDR returns to 0 on the next frame.
REQ-041 Window 0 at (1,1) and window 1 at (2,1), both enabled -> at x=2,y=1 window 0 wins, TXT_ADDR=1; at x=3,y=1 TXT_ADDR=4+1=5.
REQ-042 OVL_X changed mid-frame -> no change until after the next FRAME_START; with TXT_PX=0 the underlying pixel shows only if VTO_TRANSPARENT_EN is defined.
REQ-043 MODE=3 -> bar colours 000000, 0000FF, 00FF00, ..., FFFFFF, one per pixel at H_ACTIVE=8.
REQ-044 EN dropped mid-line, then RST_n pulsed mid-frame -> outputs idle within 1 cycle; restart begins with FRAME_START and PX_ADDR=0.
